// File: rtl/div_clk_sequencer.sv
// div_clk_sequencer
//   Steps the arbitrary clock divider through a table of (divide count,
//   dwell) entries. Dwell is measured in rising edges of the divided clock,
//   which is fed back from the divider. Playback is either one-shot or
//   looping.
//
// Optional build macro: SEQ_IRQ_EN adds a sticky completion interrupt
//   (irq / irq_ack). Without it, completion is signalled by the done pulse only.
//
// Ports
//   inclk          system clock (same clock as the divider)
//   Reset          asynchronous, active-low reset
//   cfg_wr         table write strobe (single cycle)
//   cfg_addr       table entry index
//   cfg_div        divide count for the entry
//   cfg_dwell      dwell for the entry, in divided-clock rising edges
//   last_idx       index of the final entry played (sampled live)
//   loop_en        1 = wrap to entry 0 after last_idx, 0 = one-shot
//   start          start playback pulse (ignored while busy)
//   stop           abort pulse (wins over start, no done pulse)
//   div_clk_in     divided clock, already registered in the inclk domain
//   div_clk_count  divide count driven to the divider
//   step_idx       entry currently playing
//   busy           high in LOAD/RUN
//   done           one-cycle pulse at one-shot completion
//   state_dbg      current FSM state (0 IDLE, 1 LOAD, 2 RUN, 3 DONE)
//   irq, irq_ack   (SEQ_IRQ_EN only) sticky completion interrupt and its clear
//
// Control interface: start, stop, cfg_wr and irq_ack are single-cycle
// strobes sampled on the rising edge of inclk. There is no back-pressure;
// a start that arrives while busy is dropped.
module div_clk_sequencer #(
  parameter int          DEPTH    = 8,
  parameter int          DWELL_W  = 16,
  parameter logic [31:0] IDLE_DIV = 32'd1
) (
  input  logic                     inclk,
  input  logic                     Reset,
  input  logic                     cfg_wr,
  input  logic [$clog2(DEPTH)-1:0] cfg_addr,
  input  logic [31:0]              cfg_div,
  input  logic [DWELL_W-1:0]       cfg_dwell,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     div_clk_in,
  output logic [31:0]              div_clk_count,
  output logic [$clog2(DEPTH)-1:0] step_idx,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg
`ifdef SEQ_IRQ_EN
  ,
  output logic                     irq,
  input  logic                     irq_ack
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 32 + DWELL_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             state;
  logic [AW-1:0]      idx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic               div_clk_q;
  logic [EW-1:0]      table_mem [DEPTH];

  assign state_dbg = state;

  // Table storage is deliberately not reset; software loads it before start.
  always_ff @(posedge inclk) begin
    if (cfg_wr) table_mem[cfg_addr] <= {cfg_div, cfg_dwell};
  end

  // Current entry, read live. The divide count only reaches the output in
  // LOAD, so rewriting the playing entry does not disturb the divider.
  logic [EW-1:0]      entry;
  logic [31:0]        ent_div;
  logic [DWELL_W-1:0] ent_dwell;
  logic [DWELL_W-1:0] dwell_eff;
  logic [DWELL_W:0]   cnt_plus1;
  logic               entry_finished;
  logic               is_last;
  logic [AW-1:0]      next_idx;
  logic               div_edge;

  assign entry     = table_mem[idx];
  assign ent_div   = entry[EW-1:DWELL_W];
  assign ent_dwell = entry[DWELL_W-1:0];
  // A dwell of 0 behaves exactly like a dwell of 1.
  assign dwell_eff = (ent_dwell == '0) ? DWELL_W'(1) : ent_dwell;
  // One extra bit so the +1 cannot wrap at the top of the dwell range.
  assign cnt_plus1      = {1'b0, dwell_cnt} + (DWELL_W + 1)'(1);
  assign entry_finished = (cnt_plus1 >= {1'b0, dwell_eff});
  assign is_last        = (idx == last_idx);
  // Wraps modulo DEPTH, so lowering last_idx below idx mid-run runs on to
  // DEPTH-1, wraps to 0, and then meets last_idx normally.
  assign next_idx       = idx + AW'(1);
  assign div_edge       = div_clk_in & ~div_clk_q;

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      div_clk_q <= 1'b0;
    end else begin
      div_clk_q <= div_clk_in;
    end
  end

  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      state         <= S_IDLE;
      idx           <= '0;
      dwell_cnt     <= '0;
      div_clk_count <= IDLE_DIV;
      step_idx      <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state         <= S_IDLE;
        div_clk_count <= IDLE_DIV;
        busy          <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            div_clk_count <= IDLE_DIV;
            if (start) begin
              idx   <= '0;
              busy  <= 1'b1;
              state <= S_LOAD;
            end
          end
          // Any divided-clock edge seen during LOAD is intentionally dropped.
          S_LOAD: begin
            div_clk_count <= ent_div;
            step_idx      <= idx;
            dwell_cnt     <= '0;
            state         <= S_RUN;
          end
          S_RUN: begin
            if (div_edge) begin
              if (entry_finished) begin
                if (is_last && !loop_en) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= S_DONE;
                end else begin
                  idx   <= is_last ? '0 : next_idx;
                  state <= S_LOAD;
                end
              end else begin
                dwell_cnt <= dwell_cnt + DWELL_W'(1);
              end
            end
          end
          S_DONE: begin
            div_clk_count <= IDLE_DIV;
            state         <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SEQ_IRQ_EN
  // Sticky interrupt: setting on the done pulse takes priority over a
  // simultaneous acknowledge so a completion is never lost.
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      irq <= 1'b0;
    end else if (done) begin
      irq <= 1'b1;
    end else if (irq_ack) begin
      irq <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_div_clk_sequencer.sv
// Directed bench for div_clk_sequencer: reset, start latency, one-shot and
// looping playback, zero dwell, edge dropped in LOAD, stop handling,
// asynchronous reset mid-run and (with SEQ_IRQ_EN) the sticky interrupt.
module tb_div_clk_sequencer;

  localparam int DEPTH   = 8;
  localparam int DWELL_W = 16;
  localparam int AW      = 3;

  logic               inclk = 1'b0;
  logic               Reset = 1'b0;
  logic               cfg_wr = 1'b0;
  logic [AW-1:0]      cfg_addr = '0;
  logic [31:0]        cfg_div = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [AW-1:0]      last_idx = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               div_clk_in = 1'b0;
  logic [31:0]        div_clk_count;
  logic [AW-1:0]      step_idx;
  logic               busy;
  logic               done;
  logic [1:0]         state_dbg;
`ifdef SEQ_IRQ_EN
  logic               irq;
  logic               irq_ack = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  div_clk_sequencer #(.DEPTH(DEPTH), .DWELL_W(DWELL_W), .IDLE_DIV(32'd1)) dut (
    .inclk(inclk), .Reset(Reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr),
    .cfg_div(cfg_div), .cfg_dwell(cfg_dwell), .last_idx(last_idx),
    .loop_en(loop_en), .start(start), .stop(stop), .div_clk_in(div_clk_in),
    .div_clk_count(div_clk_count), .step_idx(step_idx), .busy(busy),
    .done(done), .state_dbg(state_dbg)
`ifdef SEQ_IRQ_EN
    , .irq(irq), .irq_ack(irq_ack)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 inclk = ~inclk;

  // Count done pulses away from the active edge.
  always @(negedge inclk) if (done === 1'b1) done_cnt++;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge inclk);
    #1;
  endtask

  task automatic write_entry(input int a, input int d, input int w);
    cfg_wr = 1'b1; cfg_addr = AW'(a); cfg_div = 32'(d); cfg_dwell = DWELL_W'(w);
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic load_std_table();
    write_entry(0, 10, 2);
    write_entry(1, 20, 3);
    write_entry(2, 40, 1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    n_checks++;
    if (div_clk_count !== 32'd1) begin n_fail++; $display("FAIL reset_count got %0d exp 1", div_clk_count); end
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL reset_flags busy=%b done=%b exp 0 0", busy, done); end
    n_checks++;
    if (step_idx !== 3'd0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_idx step=%0d state=%0d exp 0 0", step_idx, state_dbg); end
  endtask

  task automatic test_start_latency();
    load_std_table();
    pulse_start();
    n_checks++;
    if (div_clk_count !== 32'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL start_lat1 count=%0d busy=%b exp 1 1", div_clk_count, busy); end
    tick();
    n_checks++;
    if (div_clk_count !== 32'd10 || busy !== 1'b1) begin n_fail++; $display("FAIL start_lat2 count=%0d busy=%b exp 10 1", div_clk_count, busy); end
    pulse_stop();
  endtask

  task automatic test_one_shot();
    logic [31:0] exp_c [6] = '{32'd10, 32'd20, 32'd20, 32'd20, 32'd40, 32'd1};
    logic [AW-1:0] exp_s [6] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2};
    logic [31:0] prev = 32'd10;
    int d0 = done_cnt;
    last_idx = 3'd2; loop_en = 1'b0;
    pulse_start();
    tick();
    for (int e = 0; e < 6; e++) begin
      div_clk_in = 1'b1;
      tick();
      n_checks++;
      if (div_clk_count !== prev) begin n_fail++; $display("FAIL os_hold e%0d got %0d exp %0d", e + 1, div_clk_count, prev); end
      if (e == 5) begin
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL os_done done=%b busy=%b exp 1 0", done, busy); end
      end
      div_clk_in = 1'b0;
      tick();
      n_checks++;
      if (div_clk_count !== exp_c[e] || step_idx !== exp_s[e]) begin
        n_fail++; $display("FAIL os_step e%0d count=%0d idx=%0d exp %0d %0d", e + 1, div_clk_count, step_idx, exp_c[e], exp_s[e]);
      end
      prev = exp_c[e];
      if (e == 2) begin
        // start while busy must be ignored
        pulse_start();
        n_checks++;
        if (step_idx !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL os_busy_start idx=%0d busy=%b exp 1 1", step_idx, busy); end
      end
    end
    n_checks++;
    if (done_cnt - d0 !== 1 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL os_end pulses=%0d busy=%b state=%0d exp 1 0 0", done_cnt - d0, busy, state_dbg);
    end
  endtask

  task automatic test_loop();
    logic [31:0] exp_c [12] = '{32'd10, 32'd20, 32'd20, 32'd20, 32'd40, 32'd10,
                                32'd10, 32'd20, 32'd20, 32'd20, 32'd40, 32'd10};
    logic [AW-1:0] exp_s [12] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0,
                                  3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd0};
    int d0 = done_cnt;
    last_idx = 3'd2; loop_en = 1'b1;
    pulse_start();
    tick();
    for (int e = 0; e < 12; e++) begin
      div_clk_in = 1'b1; tick();
      div_clk_in = 1'b0; tick();
      n_checks++;
      if (div_clk_count !== exp_c[e] || step_idx !== exp_s[e]) begin
        n_fail++; $display("FAIL loop_step e%0d count=%0d idx=%0d exp %0d %0d", e + 1, div_clk_count, step_idx, exp_c[e], exp_s[e]);
      end
    end
    n_checks++;
    if (done_cnt !== d0 || busy !== 1'b1) begin n_fail++; $display("FAIL loop_nodone pulses=%0d busy=%b exp 0 1", done_cnt - d0, busy); end
    pulse_stop();
    loop_en = 1'b0;
  endtask

  task automatic test_zero_dwell();
    int d0 = done_cnt;
    write_entry(0, 10, 0);
    write_entry(1, 20, 1);
    last_idx = 3'd1;
    pulse_start();
    tick();
    div_clk_in = 1'b1; tick();
    div_clk_in = 1'b0; tick();
    n_checks++;
    if (div_clk_count !== 32'd20 || step_idx !== 3'd1) begin n_fail++; $display("FAIL zd_adv count=%0d idx=%0d exp 20 1", div_clk_count, step_idx); end
    div_clk_in = 1'b1; tick();
    div_clk_in = 1'b0; tick();
    n_checks++;
    if (div_clk_count !== 32'd1 || done_cnt - d0 !== 1) begin n_fail++; $display("FAIL zd_end count=%0d pulses=%0d exp 1 1", div_clk_count, done_cnt - d0); end
  endtask

  task automatic test_load_edge_drop();
    write_entry(0, 10, 1);
    write_entry(1, 20, 1);
    last_idx = 3'd1;
    pulse_start();      // now in LOAD
    div_clk_in = 1'b1;  // rising edge lands on the LOAD cycle
    tick();
    div_clk_in = 1'b0;
    tick(); tick();
    n_checks++;
    if (div_clk_count !== 32'd10 || step_idx !== 3'd0) begin n_fail++; $display("FAIL load_drop count=%0d idx=%0d exp 10 0", div_clk_count, step_idx); end
    div_clk_in = 1'b1; tick();
    div_clk_in = 1'b0; tick();
    n_checks++;
    if (div_clk_count !== 32'd20) begin n_fail++; $display("FAIL load_drop_adv count=%0d exp 20", div_clk_count); end
    pulse_stop();
  endtask

  task automatic test_stop();
    int d0;
    load_std_table();
    last_idx = 3'd2; loop_en = 1'b0;
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    tick();
    n_checks++;
    if (state_dbg !== 2'd0 || busy !== 1'b0 || div_clk_count !== 32'd1) begin
      n_fail++; $display("FAIL stop_start state=%0d busy=%b count=%0d exp 0 0 1", state_dbg, busy, div_clk_count);
    end
    d0 = done_cnt;
    pulse_start();
    tick();
    for (int e = 0; e < 2; e++) begin
      div_clk_in = 1'b1; tick();
      div_clk_in = 1'b0; tick();
    end
    n_checks++;
    if (div_clk_count !== 32'd20) begin n_fail++; $display("FAIL stop_pre count=%0d exp 20", div_clk_count); end
    pulse_stop();
    n_checks++;
    if (div_clk_count !== 32'd1 || busy !== 1'b0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL stop_run count=%0d busy=%b state=%0d exp 1 0 0", div_clk_count, busy, state_dbg);
    end
    tick(); tick();
    n_checks++;
    if (done_cnt !== d0) begin n_fail++; $display("FAIL stop_nodone pulses=%0d exp 0", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    pulse_start();
    tick();
    div_clk_in = 1'b1; tick();
    div_clk_in = 1'b0; tick();
    #2 Reset = 1'b0;
    #1;
    n_checks++;
    if (div_clk_count !== 32'd1 || busy !== 1'b0 || step_idx !== 3'd0 || state_dbg !== 2'd0) begin
      n_fail++; $display("FAIL reset_mid count=%0d busy=%b idx=%0d state=%0d exp 1 0 0 0", div_clk_count, busy, step_idx, state_dbg);
    end
    tick();
    Reset = 1'b1;
    tick();
  endtask

`ifdef SEQ_IRQ_EN
  task automatic test_irq();
    load_std_table();
    last_idx = 3'd2; loop_en = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_init got %b exp 0", irq); end
    pulse_start();
    tick();
    for (int e = 0; e < 6; e++) begin
      div_clk_in = 1'b1; tick();
      div_clk_in = 1'b0; tick();
    end
    tick(); tick();
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set got %b exp 1", irq); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL irq_ack got %b exp 0", irq); end
    // acknowledge held through the done cycle: set must win
    pulse_start();
    tick();
    for (int e = 0; e < 5; e++) begin
      div_clk_in = 1'b1; tick();
      div_clk_in = 1'b0; tick();
    end
    div_clk_in = 1'b1; tick();
    div_clk_in = 1'b0;
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_set_wins got %b exp 1", irq); end
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
  endtask
`endif

  // ---------------- sequence / report ----------------
  initial begin
    Reset = 1'b0;
    repeat (3) tick();
    Reset = 1'b1;
    tick();
    test_reset();
    test_start_latency();
    test_one_shot();
    test_loop();
    test_zero_dwell();
    test_load_edge_drop();
    test_stop();
    test_reset_mid();
`ifdef SEQ_IRQ_EN
    test_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
